// File: rtl/bus_pkg.sv
// Shared encodings for the common bus: op codes and register indices used by both
// the source mux select and the destination select.
package bus_pkg;

    typedef enum logic [1:0] {
        OP_NOP  = 2'b00,
        OP_LOAD = 2'b01,
        OP_INC  = 2'b10,
        OP_CLR  = 2'b11
    } op_t;

    localparam logic [2:0] DEST_NONE = 3'b000;

    // Register indices; identical on the source and destination side of the bus.
    localparam logic [2:0] SEL_REG0 = 3'd0;
    localparam logic [2:0] SEL_REG1 = 3'd1;
    localparam logic [2:0] SEL_REG2 = 3'd2;
    localparam logic [2:0] SEL_REG3 = 3'd3;
    localparam logic [2:0] SEL_REG4 = 3'd4;
    localparam logic [2:0] SEL_REG5 = 3'd5;
    localparam logic [2:0] SEL_REG6 = 3'd6;
    localparam logic [2:0] SEL_REG7 = 3'd7;

endpackage

// File: rtl/bus_dest_reg.sv
// One destination register: load from bus, increment with wrap flag, or clear.
module bus_dest_reg #(
    parameter int unsigned width = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             inc,
    input  logic             clr,
    input  logic [width-1:0] d,
    output logic [width-1:0] q,
    output logic             wrap
);

    logic [width-1:0] q_q, q_d;
    logic             wrap_q, wrap_d;

    always_comb begin
        q_d    = q_q;
        wrap_d = 1'b0;
        if (clr) begin
            q_d = '0;
        end else if (load) begin
            q_d = d;
        end else if (inc) begin
            q_d    = q_q + width'(1);
            wrap_d = &q_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q    <= '0;
            wrap_q <= 1'b0;
        end else begin
            q_q    <= q_d;
            wrap_q <= wrap_d;
        end
    end

    assign q    = q_q;
    assign wrap = wrap_q;

endmodule

// File: rtl/bus_dest_regs.sv
// Bus destination side: decodes dest_sel/op onto registers 1-7 and reports each
// accepted write with a one-cycle acknowledge.
import bus_pkg::*;

module bus_dest_regs #(
    parameter int unsigned width = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [width-1:0] bus_in,
    input  logic [2:0]       dest_sel,
    input  logic [1:0]       op,
    output logic [width-1:0] reg0,
    output logic [width-1:0] reg1,
    output logic [width-1:0] reg2,
    output logic [width-1:0] reg3,
    output logic [width-1:0] reg4,
    output logic [width-1:0] reg5,
    output logic [width-1:0] reg6,
    output logic [width-1:0] reg7,
    output logic             wr_ack,
    output logic [2:0]       wr_sel,
    output logic             inc_wrap
);

    logic             accept;
    logic [width-1:0] q [1:7];
    logic [7:1]       wrap;
    logic             wr_ack_q;
    logic [2:0]       wr_sel_q;

    assign accept = (op != OP_NOP) && (dest_sel != DEST_NONE);

    for (genvar i = 1; i < 8; i++) begin : g_reg
        logic hit;
        assign hit = accept && (dest_sel == 3'(i));

        bus_dest_reg #(
            .width(width)
        ) u_reg (
            .clk (clk),
            .rst (rst),
            .load(hit && (op == OP_LOAD)),
            .inc (hit && (op == OP_INC)),
            .clr (hit && (op == OP_CLR)),
            .d   (bus_in),
            .q   (q[i]),
            .wrap(wrap[i])
        );
    end

    // wr_sel deliberately holds its last index while no write is acknowledged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ack_q <= 1'b0;
            wr_sel_q <= 3'b000;
        end else begin
            wr_ack_q <= accept;
            if (accept) begin
                wr_sel_q <= dest_sel;
            end
        end
    end

    assign reg0     = '0;
    assign reg1     = q[1];
    assign reg2     = q[2];
    assign reg3     = q[3];
    assign reg4     = q[4];
    assign reg5     = q[5];
    assign reg6     = q[6];
    assign reg7     = q[7];
    assign wr_ack   = wr_ack_q;
    assign wr_sel   = wr_sel_q;
    assign inc_wrap = |wrap;

endmodule

// File: tb/tb_bus_dest_regs.sv
// Bench for bus_dest_regs: directed cases plus random ops checked every cycle
// against an eight-entry register-file model.
module tb_bus_dest_regs;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] bus_in = '0;
    logic [2:0]  dest_sel = '0;
    logic [1:0]  op = '0;
    logic [15:0] reg0, reg1, reg2, reg3, reg4, reg5, reg6, reg7;
    logic        wr_ack;
    logic [2:0]  wr_sel;
    logic        inc_wrap;

    bus_dest_regs #(
        .width(16)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .bus_in  (bus_in),
        .dest_sel(dest_sel),
        .op      (op),
        .reg0    (reg0),
        .reg1    (reg1),
        .reg2    (reg2),
        .reg3    (reg3),
        .reg4    (reg4),
        .reg5    (reg5),
        .reg6    (reg6),
        .reg7    (reg7),
        .wr_ack  (wr_ack),
        .wr_sel  (wr_sel),
        .inc_wrap(inc_wrap)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    bit chk_on = 1'b0;

    // Reference model: plain register file and last-write status.
    int unsigned m_reg [8];
    bit          m_ack;
    int unsigned m_sel;
    bit          m_wrap;

    logic [15:0] r [8];
    assign r[0] = reg0;
    assign r[1] = reg1;
    assign r[2] = reg2;
    assign r[3] = reg3;
    assign r[4] = reg4;
    assign r[5] = reg5;
    assign r[6] = reg6;
    assign r[7] = reg7;

    function automatic void chk(input string name, input int unsigned act, input int unsigned exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 8; i++) m_reg[i] = 0;
        m_ack  = 1'b0;
        m_sel  = 0;
        m_wrap = 1'b0;
    endfunction

    function automatic void model_edge(input int unsigned o, input int unsigned s,
                                       input int unsigned b);
        m_wrap = 1'b0;
        if (o != 0 && s != 0) begin
            m_ack = 1'b1;
            m_sel = s;
            case (o)
                1: m_reg[s] = b;
                2: begin
                    m_wrap   = (m_reg[s] == 32'hFFFF);
                    m_reg[s] = (m_reg[s] + 1) % 65536;
                end
                default: m_reg[s] = 0;
            endcase
        end else begin
            m_ack = 1'b0;
        end
    endfunction

    always @(negedge clk) begin
        if (chk_on) begin
            for (int i = 0; i < 8; i++) chk($sformatf("reg%0d", i), r[i], m_reg[i]);
            chk("wr_ack", wr_ack, m_ack);
            chk("wr_sel", wr_sel, m_sel);
            chk("inc_wrap", inc_wrap, m_wrap);
        end
    end

    // Called just after a falling edge; returns just after the next falling edge.
    task automatic step(input logic [1:0] o, input logic [2:0] s, input logic [15:0] b);
        op       = o;
        dest_sel = s;
        bus_in   = b;
        @(posedge clk);
        if (!rst) model_edge(o, s, b);
        @(negedge clk);
    endtask

    initial begin
        model_reset();
        #1;
        chk("reset_reg1", reg1, 0);
        chk("reset_wr_ack", wr_ack, 0);
        chk("reset_wr_sel", wr_sel, 0);
        chk("reset_inc_wrap", inc_wrap, 0);
        chk_on = 1'b1;
        @(negedge clk);
        rst = 1'b0;

        // LOAD to reg3
        step(2'b01, 3'd3, 16'hA5C3);
        chk("load_reg3", reg3, 16'hA5C3);
        chk("load_ack", wr_ack, 1);
        chk("load_sel", wr_sel, 3);
        chk("load_reg2", reg2, 0);

        // Wrapping INC on reg5
        step(2'b01, 3'd5, 16'hFFFF);
        step(2'b10, 3'd5, 16'h0000);
        chk("wrap_reg5", reg5, 0);
        chk("wrap_flag", inc_wrap, 1);
        step(2'b10, 3'd5, 16'h0000);
        chk("wrap_reg5_next", reg5, 1);
        chk("wrap_flag_next", inc_wrap, 0);

        // Back-to-back on reg2
        step(2'b01, 3'd2, 16'h0010);
        chk("b2b_load", reg2, 16'h0010);
        step(2'b10, 3'd2, 16'h0);
        chk("b2b_inc1", reg2, 16'h0011);
        step(2'b10, 3'd2, 16'h0);
        chk("b2b_inc2", reg2, 16'h0012);
        step(2'b11, 3'd2, 16'h0);
        chk("b2b_clr", reg2, 16'h0000);
        chk("b2b_ack", wr_ack, 1);

        // Discarded ops; wr_sel keeps 2
        step(2'b01, 3'd0, 16'h1234);
        chk("disc_ack", wr_ack, 0);
        chk("disc_sel", wr_sel, 2);
        chk("disc_reg0", reg0, 0);
        step(2'b00, 3'd4, 16'h1234);
        chk("nop_ack", wr_ack, 0);
        chk("nop_reg4", reg4, 0);
        chk("nop_sel", wr_sel, 2);

        // LOAD of a register onto itself
        step(2'b01, 3'd3, reg3);
        chk("self_load", reg3, 16'hA5C3);
        chk("self_ack", wr_ack, 1);

        // Async reset mid-cycle after loads
        step(2'b01, 3'd7, 16'hBEEF);
        step(2'b10, 3'd5, 16'h0);
        #2 rst = 1'b1;
        #1;
        model_reset();
        chk("arst_reg3", reg3, 0);
        chk("arst_reg5", reg5, 0);
        chk("arst_reg7", reg7, 0);
        chk("arst_ack", wr_ack, 0);
        chk("arst_sel", wr_sel, 0);
        @(negedge clk);
        step(2'b01, 3'd6, 16'h5555);  // lost while rst high
        chk("rst_lost", reg6, 0);
        rst = 1'b0;

        // Random cross-check
        for (int n = 0; n < 1000; n++) begin
            logic [15:0] b;
            b = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
            step(2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), b);
        end

        chk_on = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
